// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   rv32i_defs      : datapath widths (WORD_WIDTH, SHAMT_WIDTH)
//   alu_defs        : ALU operation codes, request/response structs, legality check
//   alu_arbiter_pkg : arbiter FSM state type
// No ports; packages only.

package rv32i_defs;
   localparam int WORD_WIDTH  = 32;
   localparam int SHAMT_WIDTH = 5;
endpackage

package alu_defs;
   import rv32i_defs::*;

   localparam int ALU_CTL_WIDTH = 4;
   localparam int UIMM_SHIFT    = 12;
   // Response id field sized for the largest supported requester count (8).
   localparam int RSP_ID_MAX_W  = 3;

   localparam logic [ALU_CTL_WIDTH-1:0] ALU_ADD   = 4'd0;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_SUB   = 4'd1;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLL   = 4'd2;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLT   = 4'd3;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLTU  = 4'd4;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_XOR   = 4'd5;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_SRL   = 4'd6;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_SRA   = 4'd7;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_OR    = 4'd8;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_AND   = 4'd9;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_LUI   = 4'd10;
   localparam logic [ALU_CTL_WIDTH-1:0] ALU_AUIPC = 4'd11;

   typedef struct packed {
      logic [WORD_WIDTH-1:0]    a;
      logic [WORD_WIDTH-1:0]    b;
      logic [ALU_CTL_WIDTH-1:0] ctl;
   } alu_req_t;

   typedef struct packed {
      logic [WORD_WIDTH-1:0]   data;
      logic [RSP_ID_MAX_W-1:0] id;
      logic                    err;
   } alu_rsp_t;

   function automatic logic alu_ctl_legal(input logic [ALU_CTL_WIDTH-1:0] ctl);
      case (ctl)
         ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
         ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
endpackage

package alu_arbiter_pkg;
   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_FULL = 1'b1
   } arb_state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus of the ALU arbiter.
//   req_valid/req_ready : per-requester handshake
//   req_a/req_b/req_ctl : per-requester operands and op code
//   rsp_valid/rsp_ready : shared response handshake
//   rsp_data/rsp_id/rsp_err : result, issuing requester, illegal-op flag
// modport master: requesters + response consumer; modport slave: arbiter.

interface alu_arbiter_if
   import rv32i_defs::*;
   import alu_defs::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = $clog2(N_REQ)
);
   logic [N_REQ-1:0]                      req_valid;
   logic [N_REQ-1:0][WORD_WIDTH-1:0]      req_a;
   logic [N_REQ-1:0][WORD_WIDTH-1:0]      req_b;
   logic [N_REQ-1:0][ALU_CTL_WIDTH-1:0]   req_ctl;
   logic [N_REQ-1:0]                      req_ready;
   logic                                  rsp_valid;
   logic                                  rsp_ready;
   logic [WORD_WIDTH-1:0]                 rsp_data;
   logic [ID_W-1:0]                       rsp_id;
   logic                                  rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_ctl, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_ctl, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational RV32I ALU.
//   a_i, b_i : operands
//   ctl_i    : ALU_* operation code
//   res_o    : result (0 for undefined codes)

module alu
   import rv32i_defs::*;
   import alu_defs::*;
(
   input  logic [WORD_WIDTH-1:0]    a_i,
   input  logic [WORD_WIDTH-1:0]    b_i,
   input  logic [ALU_CTL_WIDTH-1:0] ctl_i,
   output logic [WORD_WIDTH-1:0]    res_o
);
   logic [SHAMT_WIDTH-1:0] shamt;

   assign shamt = b_i[SHAMT_WIDTH-1:0];

   always_comb begin
      res_o = '0;
      case (ctl_i)
         ALU_ADD:   res_o = a_i + b_i;
         ALU_SUB:   res_o = a_i - b_i;
         ALU_SLL:   res_o = a_i << shamt;
         ALU_SLT:   res_o = {{(WORD_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_SLTU:  res_o = {{(WORD_WIDTH-1){1'b0}}, (a_i < b_i)};
         ALU_XOR:   res_o = a_i ^ b_i;
         ALU_SRL:   res_o = a_i >> shamt;
         ALU_SRA:   res_o = $signed(a_i) >>> shamt;
         ALU_OR:    res_o = a_i | b_i;
         ALU_AND:   res_o = a_i & b_i;
         // b carries the 20-bit upper immediate, a carries the pc
         ALU_LUI:   res_o = b_i << UIMM_SHIFT;
         ALU_AUIPC: res_o = a_i + (b_i << UIMM_SHIFT);
         default:   res_o = '0;
      endcase
   end
endmodule

// File: rtl/alu_arbiter.sv
// Arbiter sharing one ALU between N_REQ requesters with a one-deep
// registered response slot tagged with the requester id.
//   clk, rst_n : clock, async active-low reset
//   arb_if     : alu_arbiter_if.slave (request and response channels)
// ALU_ARB_RR_EN defined   : round-robin grant starting at ptr_q
// ALU_ARB_RR_EN undefined : fixed priority, lowest index wins
//
// state    | meaning
// ARB_IDLE | response slot empty, rsp_valid = 0
// ARB_FULL | response slot holds a result, rsp_valid = 1

module alu_arbiter
   import rv32i_defs::*;
   import alu_defs::*;
   import alu_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  arb_if
);
   arb_state_t            state_q, state_d;
   alu_rsp_t              rsp_q, rsp_d;
   logic [ID_W-1:0]       ptr;
   logic [ID_W-1:0]       rot_idx;
   logic [N_REQ-1:0]      rot_valid;
   logic                  grant_found;
   logic [ID_W-1:0]       grant_idx;
   logic                  slot_free;
   logic                  accept;
   logic                  ctl_legal;
   alu_req_t              sel_req;
   alu_req_t              alu_req;
   logic [WORD_WIDTH-1:0] alu_res;
   logic                  unused_rsp_id;

`ifdef ALU_ARB_RR_EN
   logic [ID_W-1:0] ptr_q, ptr_d;

   assign ptr = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`else
   assign ptr = '0;
`endif

   // Rotate so the pointed-to requester sits at bit 0, then take the lowest set bit.
   always_comb begin
      rot_valid   = '0;
      rot_idx     = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot_idx      = ID_W'((i + int'(ptr)) % N_REQ);
         rot_valid[i] = arb_if.req_valid[rot_idx];
      end
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (rot_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'((i + int'(ptr)) % N_REQ);
         end
      end
   end

   // rst_n gating keeps req_ready low while reset is held.
   assign slot_free = (state_q == ARB_IDLE) || arb_if.rsp_ready;
   assign accept    = grant_found && slot_free && rst_n;

   always_comb begin
      arb_if.req_ready = '0;
      if (accept) arb_if.req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      sel_req.a   = arb_if.req_a[grant_idx];
      sel_req.b   = arb_if.req_b[grant_idx];
      sel_req.ctl = arb_if.req_ctl[grant_idx];
   end

   // Illegal codes never reach the ALU: substitute 0 + 0.
   assign ctl_legal = alu_ctl_legal(sel_req.ctl);

   always_comb begin
      alu_req = sel_req;
      if (!ctl_legal) begin
         alu_req.a   = '0;
         alu_req.b   = '0;
         alu_req.ctl = ALU_ADD;
      end
   end

   alu u_alu (
      .a_i   (alu_req.a),
      .b_i   (alu_req.b),
      .ctl_i (alu_req.ctl),
      .res_o (alu_res)
   );

   always_comb begin
      state_d = state_q;
      rsp_d   = rsp_q;
      case (state_q)
         ARB_IDLE: if (accept) state_d = ARB_FULL;
         ARB_FULL: if (arb_if.rsp_ready && !accept) state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
      if (accept) begin
         rsp_d.data = ctl_legal ? alu_res : '0;
         rsp_d.id   = RSP_ID_MAX_W'(grant_idx);
         rsp_d.err  = !ctl_legal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         rsp_q   <= rsp_d;
      end
   end

   assign arb_if.rsp_valid = (state_q == ARB_FULL);
   assign arb_if.rsp_data  = rsp_q.data;
   assign arb_if.rsp_id    = rsp_q.id[ID_W-1:0];
   assign arb_if.rsp_err   = rsp_q.err;
   assign unused_rsp_id    = ^rsp_q.id;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (N_REQ = 2).
// Expected grant ids follow the build: round-robin when ALU_ARB_RR_EN is
// defined, fixed priority (lowest index) otherwise.

module tb_alu_arbiter;
   import rv32i_defs::*;
   import alu_defs::*;

`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   alu_arbiter_if #(.N_REQ(2)) arb ();

   alu_arbiter #(.N_REQ(2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (arb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic set_req(input int r, input logic [3:0] ctl,
                          input logic [31:0] a, input logic [31:0] b);
      arb.req_ctl[r] = ctl;
      arb.req_a[r]   = a;
      arb.req_b[r]   = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      set_req(0, ALU_ADD, 32'd1, 32'd1);
      set_req(1, ALU_ADD, 32'd2, 32'd2);
      arb.req_valid = 2'b01;
      arb.rsp_ready = 1'b1;
      #12;
      checks++; if (arb.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected %b", arb.req_ready, 2'b00); end
      checks++; if (arb.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected %b", arb.rsp_valid, 1'b0); end
      checks++; if (arb.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected %h", arb.rsp_data, 32'h0); end
      checks++; if (arb.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b expected %b", arb.rsp_id, 1'b0); end
      checks++; if (arb.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected %b", arb.rsp_err, 1'b0); end
      arb.req_valid = 2'b00;
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (arb.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_after: got %b expected %b", arb.rsp_valid, 1'b0); end
   endtask

   task automatic test_add();
      set_req(0, ALU_ADD, 32'd5, 32'd7);
      arb.req_valid = 2'b01;
      arb.rsp_ready = 1'b1;
      #3;
      checks++; if (arb.req_ready !== 2'b01) begin errors++; $display("FAIL add_req_ready: got %b expected %b", arb.req_ready, 2'b01); end
      @(posedge clk); #1;
      arb.req_valid = 2'b00;
      checks++; if (arb.rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid: got %b expected %b", arb.rsp_valid, 1'b1); end
      checks++; if (arb.rsp_data !== 32'd12) begin errors++; $display("FAIL add_rsp_data: got %h expected %h", arb.rsp_data, 32'd12); end
      checks++; if (arb.rsp_id !== 1'b0) begin errors++; $display("FAIL add_rsp_id: got %b expected %b", arb.rsp_id, 1'b0); end
      checks++; if (arb.rsp_err !== 1'b0) begin errors++; $display("FAIL add_rsp_err: got %b expected %b", arb.rsp_err, 1'b0); end
      @(posedge clk); #1;
      checks++; if (arb.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected %b", arb.rsp_valid, 1'b0); end
   endtask

   task automatic test_back_to_back();
      logic        exp_id;
      logic [31:0] exp_data;
      logic [1:0]  exp_rdy;
      do_reset();
      set_req(0, ALU_SUB, 32'd10, 32'd3);
      set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
      arb.req_valid = 2'b11;
      arb.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_id   = RR ? k[0] : 1'b0;
         exp_data = exp_id ? 32'd1 : 32'd7;
         exp_rdy  = exp_id ? 2'b10 : 2'b01;
         #3;
         checks++; if (arb.req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_req_ready[%0d]: got %b expected %b", k, arb.req_ready, exp_rdy); end
         @(posedge clk); #1;
         checks++; if (arb.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_valid[%0d]: got %b expected %b", k, arb.rsp_valid, 1'b1); end
         checks++; if (arb.rsp_id !== exp_id) begin errors++; $display("FAIL b2b_rsp_id[%0d]: got %b expected %b", k, arb.rsp_id, exp_id); end
         checks++; if (arb.rsp_data !== exp_data) begin errors++; $display("FAIL b2b_rsp_data[%0d]: got %h expected %h", k, arb.rsp_data, exp_data); end
      end
      arb.req_valid = 2'b00;
      @(posedge clk); #1;
      checks++; if (arb.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected %b", arb.rsp_valid, 1'b0); end
   endtask

   task automatic test_stall();
      set_req(0, ALU_SRA, 32'h8000_0000, 32'd4);
      arb.req_valid = 2'b01;
      arb.rsp_ready = 1'b0;
      @(posedge clk); #1;
      set_req(1, ALU_ADD, 32'd1, 32'd2);
      arb.req_valid = 2'b11;
      for (int k = 0; k < 3; k++) begin
         checks++; if (arb.rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_rsp_valid[%0d]: got %b expected %b", k, arb.rsp_valid, 1'b1); end
         checks++; if (arb.rsp_data !== 32'hF800_0000) begin errors++; $display("FAIL stall_rsp_data[%0d]: got %h expected %h", k, arb.rsp_data, 32'hF800_0000); end
         checks++; if (arb.rsp_id !== 1'b0) begin errors++; $display("FAIL stall_rsp_id[%0d]: got %b expected %b", k, arb.rsp_id, 1'b0); end
         checks++; if (arb.req_ready !== 2'b00) begin errors++; $display("FAIL stall_req_ready[%0d]: got %b expected %b", k, arb.req_ready, 2'b00); end
         @(posedge clk); #1;
      end
      arb.req_valid = 2'b10;
      arb.rsp_ready = 1'b1;
      #3;
      checks++; if (arb.req_ready !== 2'b10) begin errors++; $display("FAIL stall_release_ready: got %b expected %b", arb.req_ready, 2'b10); end
      @(posedge clk); #1;
      arb.req_valid = 2'b00;
      checks++; if (arb.rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_reload_valid: got %b expected %b", arb.rsp_valid, 1'b1); end
      checks++; if (arb.rsp_data !== 32'd3) begin errors++; $display("FAIL stall_reload_data: got %h expected %h", arb.rsp_data, 32'd3); end
      checks++; if (arb.rsp_id !== 1'b1) begin errors++; $display("FAIL stall_reload_id: got %b expected %b", arb.rsp_id, 1'b1); end
      @(posedge clk); #1;
      checks++; if (arb.rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected %b", arb.rsp_valid, 1'b0); end
   endtask

   task automatic test_illegal();
      set_req(1, 4'hF, 32'h123, 32'h456);
      arb.req_valid = 2'b10;
      arb.rsp_ready = 1'b1;
      #3;
      checks++; if (arb.req_ready !== 2'b10) begin errors++; $display("FAIL illegal_req_ready: got %b expected %b", arb.req_ready, 2'b10); end
      checks++; if (dut.u_alu.ctl_i !== ALU_ADD) begin errors++; $display("FAIL illegal_alu_ctl: got %h expected %h", dut.u_alu.ctl_i, ALU_ADD); end
      checks++; if (dut.u_alu.a_i !== 32'h0) begin errors++; $display("FAIL illegal_alu_a: got %h expected %h", dut.u_alu.a_i, 32'h0); end
      checks++; if (dut.u_alu.b_i !== 32'h0) begin errors++; $display("FAIL illegal_alu_b: got %h expected %h", dut.u_alu.b_i, 32'h0); end
      @(posedge clk); #1;
      set_req(0, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
      arb.req_valid = 2'b01;
      checks++; if (arb.rsp_valid !== 1'b1) begin errors++; $display("FAIL illegal_rsp_valid: got %b expected %b", arb.rsp_valid, 1'b1); end
      checks++; if (arb.rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_rsp_err: got %b expected %b", arb.rsp_err, 1'b1); end
      checks++; if (arb.rsp_data !== 32'h0) begin errors++; $display("FAIL illegal_rsp_data: got %h expected %h", arb.rsp_data, 32'h0); end
      checks++; if (arb.rsp_id !== 1'b1) begin errors++; $display("FAIL illegal_rsp_id: got %b expected %b", arb.rsp_id, 1'b1); end
      @(posedge clk); #1;
      arb.req_valid = 2'b00;
      checks++; if (arb.rsp_err !== 1'b0) begin errors++; $display("FAIL legal_rsp_err: got %b expected %b", arb.rsp_err, 1'b0); end
      checks++; if (arb.rsp_data !== 32'h0000_FF00) begin errors++; $display("FAIL legal_rsp_data: got %h expected %h", arb.rsp_data, 32'h0000_FF00); end
      checks++; if (arb.rsp_id !== 1'b0) begin errors++; $display("FAIL legal_rsp_id: got %b expected %b", arb.rsp_id, 1'b0); end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      set_req(0, ALU_ADD, 32'd1, 32'd1);
      set_req(1, ALU_ADD, 32'd4, 32'd4);
      arb.req_valid = 2'b01;
      arb.rsp_ready = 1'b0;
      @(posedge clk); #1;
      arb.req_valid = 2'b11;
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (arb.rsp_valid !== 1'b0) begin errors++; $display("FAIL areset_rsp_valid: got %b expected %b", arb.rsp_valid, 1'b0); end
      checks++; if (arb.rsp_data !== 32'h0) begin errors++; $display("FAIL areset_rsp_data: got %h expected %h", arb.rsp_data, 32'h0); end
      checks++; if (arb.req_ready !== 2'b00) begin errors++; $display("FAIL areset_req_ready: got %b expected %b", arb.req_ready, 2'b00); end
      #1;
      rst_n = 1'b1;
      arb.rsp_ready = 1'b1;
      #1;
      checks++; if (arb.req_ready !== 2'b01) begin errors++; $display("FAIL areset_next_grant: got %b expected %b", arb.req_ready, 2'b01); end
      @(posedge clk); #1;
      arb.req_valid = 2'b00;
      checks++; if (arb.rsp_id !== 1'b0) begin errors++; $display("FAIL areset_rsp_id: got %b expected %b", arb.rsp_id, 1'b0); end
      checks++; if (arb.rsp_data !== 32'd2) begin errors++; $display("FAIL areset_rsp_data_after: got %h expected %h", arb.rsp_data, 32'd2); end
      @(posedge clk); #1;
   endtask

   task automatic test_auipc();
      set_req(0, ALU_AUIPC, 32'h0000_1000, 32'h0000_0002);
      arb.req_valid = 2'b01;
      arb.rsp_ready = 1'b1;
      @(posedge clk); #1;
      arb.req_valid = 2'b00;
      checks++; if (arb.rsp_valid !== 1'b1) begin errors++; $display("FAIL auipc_rsp_valid: got %b expected %b", arb.rsp_valid, 1'b1); end
      checks++; if (arb.rsp_data !== 32'h0000_3000) begin errors++; $display("FAIL auipc_rsp_data: got %h expected %h", arb.rsp_data, 32'h0000_3000); end
      @(posedge clk); #1;
      checks++; if (arb.rsp_valid !== 1'b0) begin errors++; $display("FAIL auipc_drain: got %b expected %b", arb.rsp_valid, 1'b0); end
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      rst_n         = 1'b0;
      arb.req_valid = '0;
      arb.req_a     = '0;
      arb.req_b     = '0;
      arb.req_ctl   = '0;
      arb.rsp_ready = 1'b0;
      test_reset();
      test_add();
      test_back_to_back();
      test_stall();
      test_illegal();
      test_async_reset();
      test_auipc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one combinational RV32I ALU (instantiated inside) between `N_REQ` requesters, such as the execute stage and a branch/address unit. Each requester uses a valid/ready request channel. Every accepted operation produces exactly one registered response on a shared response channel, tagged with the requester ID. The block holds one operation in flight and sustains one operation per cycle when the response is consumed immediately.

## Interface
- `N_REQ`, default 2: number of requesters, range 2..8.
- `ID_W`, default `$clog2(N_REQ)`: requester ID width, minimum 1.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, `N_REQ`: request valid, one bit per requester.
- `req_a`, in, `N_REQ`×`WORD_WIDTH`: operand a for each requester.
- `req_b`, in, `N_REQ`×`WORD_WIDTH`: operand b for each requester.
- `req_ctl`, in, `N_REQ`×`ALU_CTL_WIDTH`: ALU operation code for each requester.
- `req_ready`, out, `N_REQ`: one-hot or zero; high means this requester is accepted this cycle.
- `rsp_valid`, out, 1: a response is held.
- `rsp_ready`, in, 1: the consumer accepts the response.
- `rsp_data`, out, `WORD_WIDTH`: ALU result.
- `rsp_id`, out, `ID_W`: index of the requester that issued the operation.
- `rsp_err`, out, 1: the operation code was illegal; `rsp_data` is 0.

## Operation
- The response slot is free when `!rsp_valid || rsp_ready`.
- Grant is combinational and goes to the first requester with `req_valid` set, scanning from `ptr`, `ptr+1`, and so on, modulo `N_REQ`.
- `req_ready[g] = grant[g] & slot_free`. All other `req_ready` bits are 0. `req_ready` never depends on `req_valid` of other requesters beyond the grant scan.
- Accept happens when `req_valid[g] & req_ready[g]`. On the accepting clock edge:
  - `rsp_data` is loaded with the ALU result of `req_a[g]`, `req_b[g]`, `req_ctl[g]`.
  - `rsp_id` is loaded with `g`, and `rsp_valid` is set to 1.
  - `ptr` is set to `(g+1) mod N_REQ`.
- Illegal operation code (any value that is not a defined `ALU_*` code):
  - The operand path to the ALU is forced to `ALU_ADD` with operands 0, so the ALU never sees an undefined code.
  - `rsp_err` is 1 and `rsp_data` is 0.
  - The request is still accepted and the pointer still advances.
- When `rsp_valid & rsp_ready` and there is no new accept, `rsp_valid` clears to 0. When both happen in the same cycle, the slot reloads and `rsp_valid` stays 1.
- While `rsp_valid & !rsp_ready`: `rsp_data`, `rsp_id` and `rsp_err` are held stable, all `req_ready` bits are 0, and `ptr` is held.
- State is `IDLE` when `rsp_valid` is 0 and `FULL` when it is 1:
  - `IDLE` → `FULL` on accept.
  - `FULL` → `IDLE` on `rsp_ready` with no accept.
  - `FULL` → `FULL` on stall, or on `rsp_ready` with an accept.
- A requester that drops `req_valid` without being accepted loses nothing; the pointer does not move.
- Reset, asserted at any time including mid-stall:
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `rsp_err` = 0, `ptr` = 0.
  - `req_ready` = 0 while `rst_n` is low.
  - A held response is discarded.

## Timing
- Latency is 1 cycle from accept edge to `rsp_valid`.
- Throughput is 1 operation per cycle while `rsp_ready` stays high.
- `req_ready` is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
- There is no combinational path from `req_*` to any `rsp_*` output.
- Fairness: with every requester continuously valid, each is granted once every `N_REQ` accepts.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration with the `ptr` register, as described above.
- `ALU_ARB_RR_EN` undefined: fixed priority, lowest index wins. `ptr` is removed and treated as 0. Starvation of higher indices is allowed.

## Structure
- The `alu_defs` package holds:
  - the `ALU_*` operation codes and `ALU_CTL_WIDTH`;
  - a new constant function `alu_ctl_legal(ctl)` that returns 1 for defined codes;
  - typedef `alu_req_t` {a, b, ctl};
  - typedef `alu_rsp_t` {data, id, err}.
- `WORD_WIDTH` and `SHAMT_WIDTH` come from the `rv32i_defs` package.
- One sub-module: `alu`, instantiated once.
- The grant scan stays inline: one priority loop over a rotated vector.

## Test plan
- Reset, then requester 0 sends `ALU_ADD` with a=5, b=7, and `rsp_ready`=1 → `rsp_valid` next cycle with `rsp_data`=12, `rsp_id`=0, `rsp_err`=0.
- Both requesters valid for 4 cycles, `rsp_ready`=1: requester 0 sends `ALU_SUB` with 10,3; requester 1 sends `ALU_SLT` with 0xFFFFFFFF,1 → responses alternate (id 0: 7), (id 1: 1), (id 0: 7), (id 1: 1) on consecutive cycles. With `ALU_ARB_RR_EN` undefined, the id is always 0.
- `rsp_ready`=0 for 3 cycles after an `ALU_SRA` with 0x80000000,4 → `rsp_data`=0xF8000000 held stable, `req_ready`=0 throughout; with `rsp_ready`=1 and a new request in the same cycle, `rsp_valid` stays 1 and the new result appears on the next cycle.
- Illegal ctl=4'hF from requester 1 → accepted, `rsp_err`=1, `rsp_data`=0, `rsp_id`=1, and no ALU error is raised.
- `rst_n` pulsed low asynchronously (not clock-aligned) while a response is stalled → `rsp_valid` drops immediately; the next grant goes to requester 0.
- `ALU_AUIPC` with a=0x1000, b=0x2 → `rsp_data`=0x3000.
